multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Moore-style sequencer for the multicycle RV32I datapath: one shared memory, one ALU, instruction register.
- Walks each instruction through fetch, decode, execute, memory and writeback states.
- Drives every datapath select and write strobe from the current state plus the opcode.
- Replaces the single-cycle main decode path; ALU function decode stays in the existing alu_decoder.

Parameters:
- STATE_W, 4, width of the state register encoding (11 states used; fixed, not user-tuned).

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- op  input  7  opcode from instruction register
- funct3  input  3  instruction funct3
- funct7  input  7  instruction funct7 (bit 5 used)
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completion strobe (used only with MEM_WAIT_EN)
- pcwrite  output  1  PC register enable
- adrsrc  output  1  memory address select: 0=PC, 1=ALUOut
- memwrite  output  1  data memory write strobe
- irwrite  output  1  IR / OldPC capture enable
- regwrite  output  1  register file write strobe
- resultsrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
- alusrca  output  2  00=PC, 01=OldPC, 10=rs1
- alusrcb  output  2  00=rs2, 01=imm, 10=const 4
- imsrc  output  2  00=I, 01=S, 10=B, 11=J
- alucontrol  output  3  ALU operation
- illegal  output  1  one-cycle pulse in DECODE on an unsupported opcode

Behaviour:
- Opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- State register updates on posedge clk.
- If reset is high at an edge, the next state is FETCH.
- While reset is high, pcwrite, memwrite, irwrite, regwrite and illegal are forced to 0. Select outputs still follow the state.
- Reset mid-instruction: the instruction is abandoned, no strobe fires in the reset cycle, and FETCH is entered on the next edge.
- aluop is an internal 2-bit signal. alucontrol is produced by alu_decoder(aluop, funct3, funct7[5], op[5]).
- pcwrite = pcupdate | (branch & zero).
- imsrc decodes from op in every state. Unsupported opcodes give 00.
- Unlisted outputs are 0 in each state.
- State table (outputs -> next state):
  - FETCH: adrsrc=0, irwrite=1, alusrca=00, alusrcb=10, aluop=00, resultsrc=10, pcupdate=1 -> DECODE.
  - DECODE: alusrca=01, alusrcb=01, aluop=00 -> lw/sw: MEMADR; R: EXECUTER; I: EXECUTEI; jal: JAL; beq: BEQ; other: illegal=1, then FETCH.
  - MEMADR: alusrca=10, alusrcb=01, aluop=00 -> op[5] ? MEMWRITE : MEMREAD.
  - MEMREAD: resultsrc=00, adrsrc=1 -> MEMWB.
  - MEMWB: resultsrc=01, regwrite=1 -> FETCH.
  - MEMWRITE: resultsrc=00, adrsrc=1, memwrite=1 -> FETCH.
  - EXECUTER: alusrca=10, alusrcb=00, aluop=10 -> ALUWB.
  - EXECUTEI: alusrca=10, alusrcb=01, aluop=10 -> ALUWB.
  - ALUWB: resultsrc=00, regwrite=1 -> FETCH.
  - BEQ: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1 -> FETCH.
  - JAL: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcupdate=1 -> ALUWB.
- Latency in cycles:
  - lw: 5
  - sw, R-type, I-ALU, jal: 4
  - beq: 3
  - illegal opcode: 2
- An out-of-range state encoding recovers to FETCH on the next edge.

Optional Feature:
- Macro: MEM_WAIT_EN.
- Defined: FETCH, MEMREAD and MEMWRITE hold their state until mem_ready=1.
  - irwrite and pcupdate assert only in the FETCH cycle where mem_ready=1.
  - memwrite stays asserted throughout MEMWRITE until mem_ready=1.
  - reset still overrides any wait.
- Undefined: mem_ready is ignored and every state lasts exactly one cycle.

Decomposition:
- Shared package holds:
  - state enum typedef (FETCH..JAL, STATE_W bits);
  - opcode localparams;
  - resultsrc, alusrca, alusrcb and imsrc encoding constants;
  - aluop constants.
- The existing alu_decoder is instantiated unchanged.
- One new sub-module, mc_next_state: combinational next-state logic. The top holds the state register and the output decode.

Test Plan:
- Reset asserted for 2 cycles mid-MEMWB -> regwrite=0 during reset; FETCH entered on the next edge; irwrite=1 and pcwrite=1 in the first cycle after deassert.
- lw (op=0000011) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; regwrite=1 and resultsrc=01 in cycle 5 only; imsrc=00.
- sw (op=0100011) -> memwrite=1 in cycle 4 with adrsrc=1 and imsrc=01; regwrite never 1.
- beq (op=1100011):
  - zero=1 -> pcwrite=1 in cycle 3 with alucontrol=001 (sub);
  - zero=0 -> pcwrite=0 in cycle 3;
  - both: imsrc=10.
- add then jal:
  - R-type add (op=0110011, funct3=000, funct7=0) -> alucontrol=000 in EXECUTER; regwrite in ALUWB.
  - jal (op=1101111) -> pcwrite=1 in JAL; ALUWB follows; imsrc=11.
- op=1111111 -> illegal=1 for one cycle in DECODE, back to FETCH, no strobes.
- With MEM_WAIT_EN, mem_ready=0 for 3 cycles in FETCH -> state holds and irwrite=0; on mem_ready=1, irwrite=1 for one cycle.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RV32I controller.
// Latency: n/a (definitions only). Backpressure: n/a.
// Optional MEM_WAIT_EN build changes timing only, not these encodings.
package multicycle_controller_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU function decode from aluop, funct3, funct7[5] and op[5].
// Latency: combinational. Backpressure: none.
// Independent of MEM_WAIT_EN.
module alu_decoder (
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       opb5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = 3'b000;
        case (aluop)
            2'b00: alucontrol = 3'b000;
            2'b01: alucontrol = 3'b001;
            default: begin
                case (funct3)
                    // sub only for R-type with funct7[5]; addi never subtracts
                    3'b000:  alucontrol = (funct7b5 & opb5) ? 3'b001 : 3'b000;
                    3'b010:  alucontrol = 3'b101;
                    3'b110:  alucontrol = 3'b011;
                    3'b111:  alucontrol = 3'b010;
                    default: alucontrol = 3'b000;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller_next_state.sv
// Next-state logic for the multicycle controller (module mc_next_state).
// Latency: combinational. Backpressure: with MEM_WAIT_EN, FETCH/MEMREAD/MEMWRITE hold until mem_ready.
// Default build ignores mem_ready.
module mc_next_state
    import multicycle_controller_pkg::*;
(
    input  state_t     state,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output state_t     next
);

    logic mem_ok;
`ifdef MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok = 1'b1;
`endif

    always_comb begin
        next = FETCH;
        case (state)
            FETCH:    next = mem_ok ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: next = MEMADR;
                    OP_R:         next = EXECUTER;
                    OP_I:         next = EXECUTEI;
                    OP_JAL:       next = JAL;
                    OP_BEQ:       next = BEQ;
                    default:      next = FETCH;
                endcase
            end
            MEMADR:   next = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  next = mem_ok ? MEMWB : MEMREAD;
            MEMWB:    next = FETCH;
            MEMWRITE: next = mem_ok ? FETCH : MEMWRITE;
            EXECUTER: next = ALUWB;
            EXECUTEI: next = ALUWB;
            ALUWB:    next = FETCH;
            BEQ:      next = FETCH;
            JAL:      next = ALUWB;
            // unused encodings fall back to FETCH
            default:  next = FETCH;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencer for the multicycle RV32I datapath; selects/strobes from state + opcode.
// Latency: lw 5, sw/R/I/jal 4, beq 3, illegal 2 cycles. Backpressure: MEM_WAIT_EN stalls on mem_ready.
// Reset (sync, active-high) masks all write strobes and illegal.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] imsrc,
    output logic [2:0] alucontrol,
    output logic       illegal
);

    state_t     state;
    state_t     next_state;
    logic [1:0] aluop;
    logic       pcupdate;
    logic       branch;
    logic       irwrite_d;
    logic       memwrite_d;
    logic       regwrite_d;
    logic       illegal_d;
    logic       mem_ok;
    logic       unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

`ifdef MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    mc_next_state u_next (
        .state     (state),
        .op        (op),
        .mem_ready (mem_ready),
        .next      (next_state)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    always_comb begin
        adrsrc     = 1'b0;
        resultsrc  = RES_ALUOUT;
        alusrca    = SRCA_PC;
        alusrcb    = SRCB_RS2;
        aluop      = ALUOP_ADD;
        pcupdate   = 1'b0;
        branch     = 1'b0;
        irwrite_d  = 1'b0;
        memwrite_d = 1'b0;
        regwrite_d = 1'b0;
        illegal_d  = 1'b0;
        case (state)
            FETCH: begin
                irwrite_d = mem_ok;
                pcupdate  = mem_ok;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALURESULT;
            end
            DECODE: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: illegal_d = 1'b0;
                    default:                                  illegal_d = 1'b1;
                endcase
            end
            MEMADR: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
            end
            MEMREAD:  adrsrc = 1'b1;
            MEMWB: begin
                resultsrc  = RES_DATA;
                regwrite_d = 1'b1;
            end
            MEMWRITE: begin
                adrsrc     = 1'b1;
                memwrite_d = 1'b1;
            end
            EXECUTER: begin
                alusrca = SRCA_RS1;
                aluop   = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
            end
            ALUWB:    regwrite_d = 1'b1;
            BEQ: begin
                alusrca = SRCA_RS1;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
            end
            JAL: begin
                alusrca  = SRCA_OLDPC;
                alusrcb  = SRCB_FOUR;
                pcupdate = 1'b1;
            end
            default: ;
        endcase
    end

    assign pcwrite  = ~reset & (pcupdate | (branch & zero));
    assign irwrite  = ~reset & irwrite_d;
    assign memwrite = ~reset & memwrite_d;
    assign regwrite = ~reset & regwrite_d;
    assign illegal  = ~reset & illegal_d;
    assign imsrc    = imm_sel(op);

    alu_decoder u_aludec (
        .aluop      (aluop),
        .funct3     (funct3),
        .funct7b5   (funct7[5]),
        .opb5       (op[5]),
        .alucontrol (alucontrol)
    );

endmodule
